// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle MUL/DIV unit: FSM states, op select, decoder functs.
// Pure declarations; no logic, so no latency or backpressure of its own.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] FUNCT_MUL = 6'b011000;
  localparam logic [5:0] FUNCT_DIV = 6'b011010;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the decoder and the MUL/DIV sequencer.
// Busy is the only backpressure: start is ignored while an operation is in flight.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             op_div;
  logic             op_signed;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_div, op_signed, src_a, src_b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op_div, op_signed, src_a, src_b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
// Zero latency, no handshake; the sequencer decides when to register the result.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] shreg_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic             div_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] shreg_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // Multiply: acc holds the running upper half, shreg the multiplier shifting out LSB-first.
  assign sum = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, operand_i} : '0);

  // Divide: when the trial subtract succeeds the remainder is below the divisor, so it fits WIDTH bits.
  assign shifted = {acc_i, shreg_i[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, operand_i});
  assign diff    = shifted[WIDTH-1:0] - operand_i;

  always_comb begin
    acc_o   = sum[WIDTH:1];
    shreg_o = {sum[0], shreg_i[WIDTH-1:1]};
    if (div_i == OP_DIV) begin
      acc_o   = ge ? diff : shifted[WIDTH-1:0];
      shreg_o = {shreg_i[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MUL/DIV controller writing HI/LO; done pulses WIDTH+1 edges after the start edge.
// busy stays high from the start edge to the done cycle; start is ignored while busy.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic             op_div_q;
  logic             dz_q;
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   shreg_d;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;
  logic               neg_a_in;
  logic               neg_b_in;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   orig_a;

  assign neg_a_in = bus.op_signed & bus.src_a[WIDTH-1];
  assign neg_b_in = bus.op_signed & bus.src_b[WIDTH-1];
  assign mag_a    = neg_a_in ? -bus.src_a : bus.src_a;
  assign mag_b    = neg_b_in ? -bus.src_b : bus.src_b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i     (acc_q),
    .shreg_i   (shreg_q),
    .operand_i (op_div_q ? opb_q : opa_q),
    .div_i     (op_div_q),
    .acc_o     (acc_d),
    .shreg_o   (shreg_d)
  );

  // Sign fix-up; most-negative / -1 needs no special case because the magnitude quotient already wraps.
  assign prod     = {acc_q, shreg_q};
  assign prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? -shreg_q : shreg_q;
  assign rem_fix  = sign_a_q ? -acc_q : acc_q;
  assign orig_a   = sign_a_q ? -opa_q : opa_q;

  always_comb begin
    hi_d = prod_fix[2*WIDTH-1:WIDTH];
    lo_d = prod_fix[WIDTH-1:0];
    if (op_div_q == OP_DIV) begin
      hi_d = dz_q ? orig_a : rem_fix;
      lo_d = dz_q ? '1 : quo_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      shreg_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      op_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            opa_q    <= mag_a;
            opb_q    <= mag_b;
            sign_a_q <= neg_a_in;
            sign_b_q <= neg_b_in;
            op_div_q <= bus.op_div;
            dz_q     <= (bus.op_div == OP_DIV) && (bus.src_b == '0);
            acc_q    <= '0;
            shreg_q  <= (bus.op_div == OP_DIV) ? mag_a : mag_b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q   <= acc_d;
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          hi_q       <= hi_d;
          lo_q       <= lo_d;
          div_zero_q <= dz_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide controller for the MIPS datapath. It executes the MUL/DIV-class R-type operations that the single-cycle ALU cannot finish in one cycle: the operation is accepted on a start pulse, run iteratively one bit per cycle, and written into architectural HI/LO registers. The busy output stalls the PC/register-write path, and done marks result availability. It sits beside the ALU and is driven by the main decoder when it sees funct MUL (6'b011000) or DIV (6'b011010).

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH each; iteration count equals WIDTH.

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  request; sampled only in IDLE.
op_div  in  1  0 = multiply, 1 = divide.
op_signed  in  1  1 = two's-complement operands, 0 = unsigned.
src_a  in  WIDTH  multiplicand / dividend (rs).
src_b  in  WIDTH  multiplier / divisor (rt).
busy  out  1  high while an operation is in flight (state != IDLE).
done  out  1  one-cycle pulse; HI/LO are valid in the same cycle.
div_zero  out  1  sticky-per-op flag; high with done when divisor was 0.
hi  out  WIDTH  product upper half / remainder.
lo  out  WIDTH  product lower half / quotient.

Behaviour:
- Reset, asynchronous with rst_n=0: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, iteration counter=0, internal operand regs=0. A reset mid-operation aborts the operation with no done pulse.
- States: IDLE, RUN, FIX.
- IDLE: on the edge where start=1, latch |src_a| and |src_b| (magnitude only if op_signed), latch sign_a, sign_b, op_div, op_signed and zero-divisor status; clear the counter; go to RUN. done deasserts after one cycle.
- RUN: one shift-add (mul) or restoring shift-subtract (div) step per edge. Counter increments each edge. After WIDTH steps (counter == WIDTH-1 at the edge) go to FIX.
- FIX: apply signs, then write hi/lo, set done=1 and div_zero, and go to IDLE, all on one edge.
- Latency: if start is sampled at edge E0, done is high in the cycle after edge E(WIDTH+1). This is fixed, including divide-by-zero. busy goes high after E0 and low in the done cycle.
- Multiply: 2*WIDTH-bit unsigned product of the magnitudes. If signed and sign_a^sign_b, negate the full 2*WIDTH result. hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide: quotient sign = sign_a^sign_b; remainder sign = sign_a (truncating division).
- Signed most-negative / -1: lo = 0x8000_0000 (wraps), hi = 0. No flag.
- Divisor 0: the iteration result is discarded. hi = src_a as latched (original signed value), lo = all ones, div_zero = 1.
- start while busy is ignored; inputs are not re-sampled. start in the done cycle (state IDLE) is accepted.
- hi/lo hold their value between operations. Inputs are don't-care outside the start edge.

Decomposition:
- Package muldiv_pkg: state encoding (IDLE/RUN/FIX), op_div encoding constants, and the funct constants MUL=6'b011000 and DIV=6'b011010 shared with the ALU decoder.
- One sub-module, muldiv_step, is combinational: a single iteration step taking the partial remainder/accumulator, operand and mode, and returning the next accumulator/shift values. The sequencer owns the FSM, counter, sign fix-up and HI/LO registers.

Test Plan:
1. Unsigned mul, a=0x0000_FFFF, b=0x0001_0000 -> done exactly 33 edges after start; hi=0x0000_0000, lo=0xFFFF_0000; busy high for 33 cycles.
2. Signed mul, a=-3, b=7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. Signed mul, 0x8000_0000 * 0x8000_0000 -> hi=0x4000_0000, lo=0.
3. Signed div, a=-7, b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. Unsigned div, 0xFFFF_FFFF / 0x10 -> lo=0x0FFF_FFFF, hi=0xF.
4. Div by zero, a=5, b=0 -> hi=5, lo=0xFFFF_FFFF, div_zero=1, same 33-edge latency. Next valid op -> div_zero=0.
5. Signed 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0, div_zero=0.
6. Control sequencing:
   - Second start pulsed at cycle 5 of a busy op -> ignored; first result intact.
   - rst_n low at cycle 10 -> busy=0, hi=lo=0, no done pulse.
   - start asserted in the done cycle -> accepted back-to-back.
